// File: rtl/mont_exp_pkg.sv
// ============================================================================
//  Module   : mont_exp_pkg
//  Purpose  : Shared state encoding and default widths for the modular
//             exponentiator and its Montgomery multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mont_exp_pkg;

    localparam int unsigned MONT_EXP_DATA_W = 1024;
    localparam int unsigned MONT_EXP_EXP_W  = 1024;
    localparam int unsigned MONT_EXP_ELEN_W = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TOMONT   = 3'd1,
        LOAD     = 3'd2,
        SQUARE   = 3'd3,
        MULT     = 3'd4,
        FROMMONT = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mont_exp_montgomery.sv
// ============================================================================
//  Module   : montgomery
//  Purpose  : Bit-serial radix-2 Montgomery multiplier.
//             result = in_a * in_b * 2^-DATA_W mod in_m (in_a, in_b < in_m,
//             in_m odd). One operand bit per cycle, done pulses once.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module montgomery
    import mont_exp_pkg::*;
#(
    parameter int unsigned DATA_W = MONT_EXP_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_m,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W+1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic              done_q;

    // Accumulator stays below 2m between steps, so two guard bits suffice.
    logic [DATA_W+1:0] sum_w;
    logic [DATA_W+1:0] red_w;
    logic [DATA_W+1:0] next_w;
    logic [DATA_W-1:0] fin_w;

    // One reduction step plus the final conditional subtraction.
    always_comb begin
        sum_w  = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
        red_w  = sum_w[0] ? (sum_w + {2'b00, m_q}) : sum_w;
        next_w = red_w >> 1;
        fin_w  = (next_w >= {2'b00, m_q}) ? DATA_W'(next_w - {2'b00, m_q})
                                           : next_w[DATA_W-1:0];
    end

    // Operand capture, iteration counter and single-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_q   <= in_a;
                b_q   <= in_b;
                m_q   <= in_m;
                acc_q <= '0;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= next_w;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    run_q    <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= fin_w;
                end
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: rtl/mont_exp.sv
// ============================================================================
//  Module   : mont_exp
//  Purpose  : Left-to-right square-and-multiply modular exponentiation
//             (result = x^e mod m) built around one Montgomery multiplier.
//             Optional macro MONT_EXP_CYCLE_CNT_EN adds a 32-bit saturating
//             busy-cycle counter output (cycle_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_exp
    import mont_exp_pkg::*;
#(
    parameter int unsigned DATA_W = MONT_EXP_DATA_W,
    parameter int unsigned EXP_W  = MONT_EXP_EXP_W,
    parameter int unsigned ELEN_W = MONT_EXP_ELEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [EXP_W-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_r2,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy
`ifdef MONT_EXP_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam int unsigned       IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(EXP_W);

    state_t            state_q, state_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] x_q;        // base, replaced by its Montgomery form
    logic [EXP_W-1:0]  e_q;
    logic [ELEN_W-1:0] elen_q;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r2_q;
    logic [DATA_W-1:0] acc_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] result_q;

    logic [DATA_W-1:0] mm_a_w;
    logic [DATA_W-1:0] mm_b_w;
    logic [DATA_W-1:0] mm_res_w;
    logic              mm_done_w;
    logic              mm_start_w;
    logic              mm_resetn_w;
    logic [ELEN_W-1:0] elen_in_w;

    assign elen_in_w   = (in_e_len > ELEN_MAX) ? ELEN_MAX : in_e_len;
    assign mm_start_w  = first_q;
    assign mm_resetn_w = ~reset;

    // State register and the first-cycle flag that forms the MM start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Next-state logic and multiplier operand selection.
    always_comb begin
        state_d = state_q;
        mm_a_w  = acc_q;
        mm_b_w  = acc_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = TOMONT;
            end
            TOMONT: begin
                mm_a_w = x_q;
                mm_b_w = r2_q;
                if (mm_done_w) state_d = LOAD;
            end
            LOAD: begin
                state_d = (elen_q == '0) ? FROMMONT : SQUARE;
            end
            SQUARE: begin
                if (mm_done_w) begin
                    if (e_q[idx_q])          state_d = MULT;
                    else if (idx_q != '0)    state_d = SQUARE;
                    else                     state_d = FROMMONT;
                end
            end
            MULT: begin
                mm_b_w = x_q;
                if (mm_done_w) state_d = (idx_q != '0) ? SQUARE : FROMMONT;
            end
            FROMMONT: begin
                mm_b_w = DATA_W'(1);
                if (mm_done_w) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new multiply starts whenever we enter an MM state, including the
        // SQUARE -> SQUARE step for a zero exponent bit.
        first_d = ((state_d == TOMONT) || (state_d == SQUARE) ||
                   (state_d == MULT)   || (state_d == FROMMONT)) &&
                  ((state_d != state_q) || mm_done_w);
    end

    // Operand latching, accumulator, bit index and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            e_q      <= '0;
            elen_q   <= '0;
            m_q      <= '0;
            r_q      <= '0;
            r2_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q    <= in_x;
                        e_q    <= in_e;
                        elen_q <= elen_in_w;
                        m_q    <= in_m;
                        r_q    <= in_r;
                        r2_q   <= in_r2;
                    end
                end
                TOMONT: begin
                    if (mm_done_w) x_q <= mm_res_w;
                end
                LOAD: begin
                    acc_q <= r_q;
                    if (elen_q != '0) idx_q <= IDX_W'(elen_q - 1'b1);
                end
                SQUARE: begin
                    if (mm_done_w) begin
                        acc_q <= mm_res_w;
                        if (!e_q[idx_q] && (idx_q != '0)) idx_q <= idx_q - 1'b1;
                    end
                end
                MULT: begin
                    if (mm_done_w) begin
                        acc_q <= mm_res_w;
                        if (idx_q != '0) idx_q <= idx_q - 1'b1;
                    end
                end
                FROMMONT: begin
                    if (mm_done_w) result_q <= mm_res_w;
                end
                default: begin
                end
            endcase
        end
    end

    montgomery #(
        .DATA_W (DATA_W)
    ) u_mm (
        .clk    (clk),
        .resetn (mm_resetn_w),
        .start  (mm_start_w),
        .in_a   (mm_a_w),
        .in_b   (mm_b_w),
        .in_m   (m_q),
        .result (mm_res_w),
        .done   (mm_done_w)
    );

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);

`ifdef MONT_EXP_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    // Busy-cycle counter: cleared on acceptance, saturates, idles frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cyc_q <= '0;
        end else if (busy && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mont_exp.sv
// ============================================================================
//  Module   : tb_mont_exp
//  Purpose  : Directed self-checking bench for mont_exp, 32-bit instance,
//             modulus m = 2^32 - 5 so R mod m = 5 and R^2 mod m = 25.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mont_exp;

    localparam int unsigned DW    = 32;
    localparam int unsigned EW    = 32;
    localparam int unsigned LW    = 6;
    localparam int          LIMIT = 5000;

    localparam logic [DW-1:0] MOD = 32'hFFFF_FFFB;
    localparam logic [DW-1:0] RM  = 32'd5;
    localparam logic [DW-1:0] R2M = 32'd25;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_x;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_e_len;
    logic [DW-1:0] in_m;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_r2;
    logic [DW-1:0] result;
    logic          done;
    logic          busy;
`ifdef MONT_EXP_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    int total;
    int bad;

    mont_exp #(
        .DATA_W (DW),
        .EXP_W  (EW),
        .ELEN_W (LW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_e_len (in_e_len),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .result   (result),
        .done     (done),
        .busy     (busy)
`ifdef MONT_EXP_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One exponentiation: start, wait for done, check result, MM count,
    // busy continuity, single done pulse and that a DONE-cycle start is ignored.
    task automatic run_exp(input logic [DW-1:0] x, input logic [EW-1:0] e,
                           input logic [LW-1:0] elen, input logic [DW-1:0] exp_res,
                           input int exp_mm, input string name, input bit poke_mid);
        int cyc;
        int mm_cnt;
        int busy_cnt;
        bit got;
        bit busy_drop;
        logic [DW-1:0] got_res;
        cyc = 0; mm_cnt = 0; busy_cnt = 0; got = 0; busy_drop = 0; got_res = '0;
        @(negedge clk);
        in_x = x; in_e = e; in_e_len = elen; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got && cyc < LIMIT) begin
            if (dut.mm_start_w) mm_cnt++;
            if (busy) busy_cnt++; else busy_drop = 1'b1;
            if (poke_mid && cyc == 40) begin
                start = 1'b1; in_x = 32'd5; in_e = 32'd1; in_e_len = 6'd1;
            end
            if (poke_mid && cyc == 41) start = 1'b0;
            if (done) begin
                got = 1'b1;
                got_res = result;
            end
            cyc++;
            if (!got) @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, LIMIT);
            return;
        end
        total++;
        if (got_res !== exp_res) begin
            bad++;
            $display("FAIL %s_result: got %h expected %h", name, got_res, exp_res);
        end
        total++;
        if (mm_cnt !== exp_mm) begin
            bad++;
            $display("FAIL %s_mm_count: got %0d expected %0d", name, mm_cnt, exp_mm);
        end
        total++;
        if (busy_drop) begin
            bad++;
            $display("FAIL %s_busy_held: busy low %0d of %0d cycles, expected 0",
                     name, cyc - busy_cnt, cyc);
        end
        // Start asserted during the DONE cycle must not be accepted.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", name, done, busy);
        end
        total++;
        if (result !== exp_res) begin
            bad++;
            $display("FAIL %s_result_hold: got %h expected %h", name, result, exp_res);
        end
`ifdef MONT_EXP_CYCLE_CNT_EN
        total++;
        if (cycle_cnt !== 32'(busy_cnt)) begin
            bad++;
            $display("FAIL %s_cycle_cnt: got %0d expected %0d", name, cycle_cnt, busy_cnt);
        end
        repeat (3) @(negedge clk);
        total++;
        if (cycle_cnt !== 32'(busy_cnt)) begin
            bad++;
            $display("FAIL %s_cycle_cnt_frozen: got %0d expected %0d", name, cycle_cnt, busy_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: result=%h done=%b busy=%b expected 0 0 0",
                     result, done, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_exp(32'd2, 32'h10, 6'd5, 32'h0001_0000, 8, "pow2_16", 1'b0);
        run_exp(32'h1234, 32'hFFFF, 6'd0, 32'd1, 2, "elen0", 1'b0);
        run_exp(32'h0001_0000, 32'd3, 6'd2, 32'h0005_0000, 6, "pow2_48", 1'b0);
        run_exp(32'd3, 32'h14, 6'd5, 32'hCFD4_1B91, 9, "pow3_20", 1'b0);
        run_exp(MOD - 1, 32'd3, 6'd2, MOD - 1, 6, "neg1_cubed", 1'b0);
    endtask

    task automatic test_boundaries();
        run_exp(32'd1, 32'hFFFF_FFFF, 6'd32, 32'd1, 66, "all_ones", 1'b0);
        run_exp(32'd2, 32'hFFFF_FF21, 6'd6, 32'd10, 10, "high_bits_ignored", 1'b0);
        run_exp(32'd2, 32'h21, 6'd63, 32'd10, 36, "elen_clamp", 1'b0);
    endtask

    task automatic test_mid_start();
        run_exp(32'h10, 32'd7, 6'd3, 32'h1000_0000, 8, "mid_start", 1'b1);
    endtask

    task automatic test_abort();
        int cyc;
        run_exp(32'd2, 32'h10, 6'd5, 32'h0001_0000, 8, "pre_abort", 1'b0);
        @(negedge clk);
        in_x = 32'd1; in_e = 32'hFFFF_FFFF; in_e_len = 6'd32; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (dut.state_q != mont_exp_pkg::SQUARE && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (dut.state_q != mont_exp_pkg::SQUARE) begin
            bad++;
            $display("FAIL abort_reach_square: state %0d expected %0d",
                     dut.state_q, mont_exp_pkg::SQUARE);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: result=%h done=%b busy=%b expected 0 0 0",
                     result, done, busy);
        end
        reset = 1'b0;
        run_exp(32'd2, 32'd31, 6'd5, 32'h8000_0000, 12, "after_abort", 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0;
        in_m = MOD; in_r = RM; in_r2 = R2M;
        test_reset();
        test_basic();
        test_boundaries();
        test_mid_start();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
